// File: rtl/tdm_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_tx_pkg
//  Description : Shared types and helpers for the two-lane TDM burst
//                transmitter: scheduler state encoding, lane index type,
//                frame length helper and state decode functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_tx_pkg;

    // Scheduler states. Bit 1 selects the lane, bit 0 marks a guard gap.
    typedef enum logic [1:0] {
        SLOT0  = 2'b00,
        GUARD0 = 2'b01,
        SLOT1  = 2'b10,
        GUARD1 = 2'b11
    } state_t;

    typedef logic lane_t;

    // Cycles in one complete frame (two slots, two guard gaps).
    function automatic int frame_len(input int burst_len, input int guard_len);
        return 2 * (burst_len + guard_len);
    endfunction

    function automatic logic is_slot(input state_t s);
        return (s == SLOT0) || (s == SLOT1);
    endfunction

    // Lane that owns the given state (slot and its following guard).
    function automatic lane_t slot_lane(input state_t s);
        return lane_t'((s == SLOT1) || (s == GUARD1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. o_rdata always presents the
//                head entry; a pop advances it. Pushes while full and pops
//                while empty are ignored.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_push/i_wdata,
//                i_pop/o_rdata, o_full, o_empty, o_count (occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] r_mem [2**c_AW];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/tdm_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_burst_tx
//  Description : Two-channel burst transmitter. Each channel is buffered in
//                its own FIFO and sent as fixed BURST_LEN bursts in its own
//                time slot of a fixed frame SLOT0-GUARD0-SLOT1-GUARD1.
//                A slot is sent in full or skipped entirely.
//  Ports       : i_clk, i_rst_n (sync, active-low)
//                i_dinN/i_dinN_valid/o_dinN_ready : channel N input stream
//                o_doutN/o_doutN_valid            : lane N output (registered)
//                o_frame_start                    : first cycle of SLOT0
//                o_skipN                          : slot N skipped (underrun)
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_burst_tx
    import tdm_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BURST_LEN  = 4,
    parameter int GUARD_LEN  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_din0,
    input  logic              i_din0_valid,
    output logic              o_din0_ready,
    input  logic [DATA_W-1:0] i_din1,
    input  logic              i_din1_valid,
    output logic              o_din1_ready,
    output logic [DATA_W-1:0] o_dout0,
    output logic              o_dout0_valid,
    output logic [DATA_W-1:0] o_dout1,
    output logic              o_dout1_valid,
    output logic              o_frame_start,
    output logic              o_skip0,
    output logic              o_skip1
);

    localparam int c_MAX_LEN = (BURST_LEN > GUARD_LEN) ? BURST_LEN : GUARD_LEN;
    localparam int c_CNT_W   = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;
    localparam int c_FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_CNT_W-1:0]  c_SLOT_LAST  = c_CNT_W'(BURST_LEN - 1);
    localparam logic [c_CNT_W-1:0]  c_GUARD_LAST = c_CNT_W'(GUARD_LEN - 1);
    localparam logic [c_FCNT_W-1:0] c_BURST_CNT  = c_FCNT_W'(BURST_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_last;

    logic [DATA_W-1:0]  w_din       [2];
    logic [1:0]         w_din_valid;

    assign w_din[0]       = i_din0;
    assign w_din[1]       = i_din1;
    assign w_din_valid[0] = i_din0_valid;
    assign w_din_valid[1] = i_din1_valid;

    // ------------------------------------------------------------------
    // Frame scheduler: fixed timing, independent of data availability.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= SLOT0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_last      = is_slot(r_state) ? (r_cnt == c_SLOT_LAST)
                                       : (r_cnt == c_GUARD_LAST);
        if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                SLOT0:   w_state_nxt = GUARD0;
                GUARD0:  w_state_nxt = SLOT1;
                SLOT1:   w_state_nxt = GUARD1;
                default: w_state_nxt = SLOT0;
            endcase
        end
    end

    // Status pulses are decoded from state; masking with the reset input
    // keeps every output quiet while reset is held.
    assign o_frame_start = i_rst_n && (r_state == SLOT0) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Per-lane buffering, slot arming and output registers.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic                w_in_slot;
        logic                w_entry;
        logic                w_enough;
        logic                w_ready;
        logic                w_push;
        logic                w_pop;
        logic                w_skip;
        logic                w_full;
        logic                w_empty;
        logic [DATA_W-1:0]   w_rdata;
        logic [c_FCNT_W-1:0] w_count;
        logic                r_armed;
        logic [DATA_W-1:0]   r_dout;
        logic                r_dout_valid;

        assign w_in_slot = is_slot(r_state) && (slot_lane(r_state) == lane_t'(l));
        assign w_entry   = w_in_slot && (r_cnt == '0);
        // Decision uses the registered occupancy, so a byte pushed in the
        // entry cycle itself does not count toward this slot.
        assign w_enough  = (w_count >= c_BURST_CNT);
        assign w_ready   = i_rst_n && !w_full;
        assign w_push    = w_din_valid[l] && w_ready;
        // The entry cycle pops immediately when armed so the burst fills
        // the slot; later slot cycles follow the armed flag.
        assign w_pop     = w_in_slot && !w_empty && (w_entry ? w_enough : r_armed);
        assign w_skip    = i_rst_n && w_entry && !w_enough;

        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (w_push),
            .i_wdata (w_din[l]),
            .i_pop   (w_pop),
            .o_rdata (w_rdata),
            .o_full  (w_full),
            .o_empty (w_empty),
            .o_count (w_count)
        );

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_armed <= 1'b0;
            end else if (w_in_slot && w_last) begin
                r_armed <= 1'b0;
            end else if (w_entry) begin
                r_armed <= w_enough;
            end
        end

        // Data holds its last value between bursts; valid is the qualifier.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_pop;
                if (w_pop) r_dout <= w_rdata;
            end
        end
    end

    assign o_din0_ready  = g_lane[0].w_ready;
    assign o_din1_ready  = g_lane[1].w_ready;
    assign o_skip0       = g_lane[0].w_skip;
    assign o_skip1       = g_lane[1].w_skip;
    assign o_dout0       = g_lane[0].r_dout;
    assign o_dout0_valid = g_lane[0].r_dout_valid;
    assign o_dout1       = g_lane[1].r_dout;
    assign o_dout1_valid = g_lane[1].r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_tdm_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_burst_tx
//  Description : Self-checking bench for tdm_burst_tx. A frame-position
//                reference model (queues plus arithmetic on the cycle index)
//                predicts every output each cycle; a vector table and a few
//                directed sequences pin down the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tdm_burst_tx;
    import tdm_tx_pkg::*;

    localparam int DW    = 8;
    localparam int BL    = 4;
    localparam int GL    = 2;
    localparam int DEPTH = 16;
    localparam int F     = frame_len(BL, GL);

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [DW-1:0] i_din0 = '0, i_din1 = '0;
    logic          i_din0_valid = 1'b0, i_din1_valid = 1'b0;
    logic          o_din0_ready, o_din1_ready;
    logic [DW-1:0] o_dout0, o_dout1;
    logic          o_dout0_valid, o_dout1_valid;
    logic          o_frame_start, o_skip0, o_skip1;

    always #5 i_clk = ~i_clk;

    tdm_burst_tx #(
        .DATA_W(DW), .BURST_LEN(BL), .GUARD_LEN(GL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_din0        (i_din0),
        .i_din0_valid  (i_din0_valid),
        .o_din0_ready  (o_din0_ready),
        .i_din1        (i_din1),
        .i_din1_valid  (i_din1_valid),
        .o_din1_ready  (o_din1_ready),
        .o_dout0       (o_dout0),
        .o_dout0_valid (o_dout0_valid),
        .o_dout1       (o_dout1),
        .o_dout1_valid (o_dout1_valid),
        .o_frame_start (o_frame_start),
        .o_skip0       (o_skip0),
        .o_skip1       (o_skip1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            c;                 // cycles since reset release
    logic [7:0]    mmem  [2][256];    // per-channel buffered bytes
    int            mh    [2];
    int            mt    [2];
    logic [7:0]    burst [2][BL];     // bytes taken at the latest armed slot
    int            e     [2];         // cycle of the latest armed slot entry
    logic [7:0]    exp_d [2];

    // Outputs sampled in the most recent cycle
    logic          s_fs;
    logic          s_sk  [2];
    logic          s_rdy [2];
    logic          s_v   [2];
    logic [7:0]    s_d   [2];

    // Random / fill source state
    logic          sv [2];
    logic [7:0]    sd [2];
    logic [7:0]    fd;
    logic          saw_low;
    int            pct;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       fs;
        logic       sk0;
        logic       sk1;
        logic       ov0;
        logic [7:0] od0;
    } vec_t;
    vec_t tv [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, c);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            mh[l] = 0; mt[l] = 0; e[l] = -100; exp_d[l] = 8'h00;
        end
        c = 0;
    endtask

    // Holds reset for n edges; after the first reset edge every output is 0.
    task automatic do_reset(input int n);
        i_rst_n = 1'b0;
        i_din0_valid = 1'b0; i_din1_valid = 1'b0;
        i_din0 = '0; i_din1 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                chk("rst_frame_start", o_frame_start, 0);
                chk("rst_skip0", o_skip0, 0);
                chk("rst_skip1", o_skip1, 0);
                chk("rst_ready0", o_din0_ready, 0);
                chk("rst_ready1", o_din1_ready, 0);
                chk("rst_valid0", o_dout0_valid, 0);
                chk("rst_valid1", o_dout1_valid, 0);
                chk("rst_dout0", o_dout0, 0);
                chk("rst_dout1", o_dout1, 0);
            end
            @(posedge i_clk); #1;
        end
        model_reset();
    endtask

    // One running cycle: drive inputs, compare all outputs with the model,
    // advance the model, then cross the clock edge.
    task automatic cycle(input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
        int p, st, sz, rem;
        logic er, ev;
        i_rst_n = 1'b1;
        i_din0_valid = v0; i_din0 = d0;
        i_din1_valid = v1; i_din1 = d1;
        @(negedge i_clk);
        s_fs = o_frame_start;
        s_sk[0] = o_skip0;       s_sk[1] = o_skip1;
        s_rdy[0] = o_din0_ready; s_rdy[1] = o_din1_ready;
        s_v[0] = o_dout0_valid;  s_v[1] = o_dout1_valid;
        s_d[0] = o_dout0;        s_d[1] = o_dout1;

        p = c % F;
        chk("frame_start", s_fs, (p == 0));
        for (int l = 0; l < 2; l++) begin
            st  = (l == 0) ? 0 : BL + GL;
            sz  = mt[l] - mh[l];
            // Bytes of the running burst still inside the FIFO.
            rem = (c > e[l] && c < e[l] + BL) ? BL - (c - e[l]) : 0;
            er  = (sz + rem) < DEPTH;
            ev  = (c > e[l]) && (c <= e[l] + BL);
            if (ev) exp_d[l] = burst[l][c - e[l] - 1];
            chk(l == 0 ? "skip0" : "skip1", s_sk[l], (p == st) && (sz < BL));
            chk(l == 0 ? "ready0" : "ready1", s_rdy[l], er);
            chk(l == 0 ? "valid0" : "valid1", s_v[l], ev);
            chk(l == 0 ? "dout0" : "dout1", s_d[l], exp_d[l]);
            if (p == st && sz >= BL) begin
                for (int k = 0; k < BL; k++) begin
                    burst[l][k] = mmem[l][mh[l] % 256];
                    mh[l]++;
                end
                e[l] = c;
            end
            if (((l == 0) ? v0 : v1) && er) begin
                mmem[l][mt[l] % 256] = (l == 0) ? d0 : d1;
                mt[l]++;
            end
        end
        chk("lanes_exclusive", s_v[0] & s_v[1], 0);
        c++;
        @(posedge i_clk); #1;
    endtask

    initial begin
        // Preload 0x10..0x13 on ch0 right after release: burst in frame 2.
        tv[ 0] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[ 1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 2] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 3] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[ 7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[ 9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
        tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        tv[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13};
        tv[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13};
        tv[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h13};
        tv[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13};

        model_reset();

        // 1) Reset release and ch0 preload, driven from the vector table.
        do_reset(3);
        for (int i = 0; i < 20; i++) begin
            cycle(tv[i].v0, tv[i].d0, 1'b0, 8'h00);
            chk("tbl_frame_start", s_fs, tv[i].fs);
            chk("tbl_skip0", s_sk[0], tv[i].sk0);
            chk("tbl_skip1", s_sk[1], tv[i].sk1);
            chk("tbl_valid0", s_v[0], tv[i].ov0);
            chk("tbl_dout0", s_d[0], tv[i].od0);
            chk("tbl_valid1", s_v[1], 0);
        end

        // 2) Three bytes on ch1 are not enough; the 4th completes a burst.
        do_reset(2);
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 8'h00, (k < 3) || (k == 7), (k == 7) ? 8'hA3 : 8'(8'hA0 + k));
            if (k == 6)  chk("ch1_short_skip", s_sk[1], 1);
            if (k == 18) chk("ch1_full_noskip", s_sk[1], 0);
            if (k >= 19 && k <= 22) begin
                chk("ch1_burst_valid", s_v[1], 1);
                chk("ch1_burst_data", s_d[1], 8'hA0 + k - 19);
            end
        end

        // 3) Continuous ch0 source until the FIFO fills; source holds data.
        do_reset(2);
        fd = 8'h00;
        saw_low = 1'b0;
        for (int k = 0; k < 48; k++) begin
            cycle(1'b1, fd, 1'b0, 8'h00);
            if (k == 19) chk("fill_ready_before_full", s_rdy[0], 1);
            if (k == 20) chk("fill_ready_at_full", s_rdy[0], 0);
            if (!s_rdy[0]) saw_low = 1'b1;
            else           fd = fd + 8'h01;
        end
        chk("fill_ready_low_seen", saw_low, 1);

        // 4) Reset at frame cycle 2 of an armed lane-0 burst, then replay.
        do_reset(2);
        for (int k = 0; k < 14; k++) begin
            cycle((k < 4), 8'(8'h10 + k), 1'b0, 8'h00);
            if (k == 13) begin
                chk("midrst_burst_running", s_v[0], 1);
                chk("midrst_burst_data", s_d[0], 8'h10);
            end
        end
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            cycle(tv[i].v0, tv[i].d0, 1'b0, 8'h00);
            chk("replay_valid0", s_v[0], tv[i].ov0);
            chk("replay_dout0", s_d[0], tv[i].od0);
            chk("replay_skip0", s_sk[0], tv[i].sk0);
        end

        // 5) Randomised streams on both channels over 100 frames.
        do_reset(2);
        sv[0] = 1'b0; sv[1] = 1'b0;
        for (int k = 0; k < 100 * F; k++) begin
            pct = 20 + 35 * ((k / (F * 25)) % 3);
            for (int l = 0; l < 2; l++) begin
                if (!sv[l]) begin
                    sv[l] = $urandom_range(0, 99) < ((l == 0) ? pct : 110 - pct);
                    sd[l] = 8'($urandom);
                end
            end
            cycle(sv[0], sd[0], sv[1], sd[1]);
            for (int l = 0; l < 2; l++) begin
                if (sv[l] && s_rdy[l]) sv[l] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
